// File: rtl/retrosoc_rst_ctrl.sv
// retrosoc_rst_ctrl: system reset controller between the pad reset and the
// retrosoc core. It synchronizes and stretches the pad reset and adds two soft
// reset sources: the housekeeping SPI reset bit and an optional trap auto-reset.
// It also records the cause of the last reset and a saturating soft-reset count.
module retrosoc_rst_ctrl #(
  parameter int unsigned HOLD_CYCLES = 16,    // 1..255
  parameter int unsigned TRAP_DLY    = 1024   // 1..65535
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       hk_rst_i,
  input  logic       trap_i,
  input  logic       trap_rst_en_i,
  output logic       sys_rst_n_o,
  output logic [1:0] rst_cause_o,
  output logic [7:0] soft_rst_cnt_o,
  output logic       hold_o
);

  typedef enum logic [1:0] {
    ST_HOLD      = 2'b00,
    ST_RUN       = 2'b01,
    ST_TRAP_WAIT = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_PAD  = 2'b00,
    CAUSE_HK   = 2'b01,
    CAUSE_TRAP = 2'b10
  } cause_e;

  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [15:0] TRAP_LAST = 16'(TRAP_DLY - 1);

  logic [1:0]  rst_sync_q;
  logic [1:0]  hk_sync_q;
  logic        rst_sync;
  logic        hk_sync;

  state_e      state_q;
  cause_e      cause_q;
  logic [7:0]  hold_cnt_q;
  logic [15:0] trap_cnt_q;
  logic [7:0]  soft_cnt_q;
  logic [7:0]  soft_cnt_d;
  logic        sys_rst_n_q;
  logic        hold_q;
  logic        trap_expire;

  // Pad reset synchronizer: asserts with rst_n_i, releases two edges later.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  // Two-flop synchronizer for the asynchronous housekeeping reset level.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) hk_sync_q <= 2'b00;
    else          hk_sync_q <= {hk_sync_q[0], hk_rst_i};
  end

  assign rst_sync = rst_sync_q[1];
  assign hk_sync  = hk_sync_q[1];

  // Saturating increment of the soft-reset counter.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    soft_cnt_d = soft_cnt_q;
    if (soft_cnt_q != 8'hFF) soft_cnt_d = soft_cnt_q + 8'd1;
  end

  // Trap has been held for the full delay while waiting.
  assign trap_expire = trap_i && (trap_cnt_q == TRAP_LAST);

  // Reset FSM with registered system reset, hold flag, cause and count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      trap_cnt_q  <= '0;
      sys_rst_n_q <= 1'b0;
      hold_q      <= 1'b1;
      cause_q     <= CAUSE_PAD;
      soft_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          // Stretch only counts once every source has released.
          if (!rst_sync || hk_sync) begin
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q     <= ST_RUN;
            sys_rst_n_q <= 1'b1;
            hold_q      <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        ST_RUN: begin
          if (hk_sync) begin
            state_q     <= ST_HOLD;
            sys_rst_n_q <= 1'b0;
            hold_q      <= 1'b1;
            hold_cnt_q  <= '0;
            cause_q     <= CAUSE_HK;
            soft_cnt_q  <= soft_cnt_d;
          end else if (trap_i && trap_rst_en_i) begin
            state_q    <= ST_TRAP_WAIT;
            trap_cnt_q <= '0;
          end
        end
        ST_TRAP_WAIT: begin
          // Housekeeping wins over a simultaneous trap expiry.
          if (hk_sync || trap_expire) begin
            state_q     <= ST_HOLD;
            sys_rst_n_q <= 1'b0;
            hold_q      <= 1'b1;
            hold_cnt_q  <= '0;
            cause_q     <= hk_sync ? CAUSE_HK : CAUSE_TRAP;
            soft_cnt_q  <= soft_cnt_d;
          end else if (!trap_i) begin
            state_q <= ST_RUN;
          end else begin
            trap_cnt_q <= trap_cnt_q + 16'd1;
          end
        end
        default: begin
          state_q     <= ST_HOLD;
          sys_rst_n_q <= 1'b0;
          hold_q      <= 1'b1;
          hold_cnt_q  <= '0;
        end
      endcase
    end
  end

  assign sys_rst_n_o    = sys_rst_n_q;
  assign hold_o         = hold_q;
  assign rst_cause_o    = cause_q;
  assign soft_rst_cnt_o = soft_cnt_q;

endmodule

// File: tb/tb_retrosoc_rst_ctrl.sv
// Directed self-checking bench for retrosoc_rst_ctrl (HOLD_CYCLES=16, TRAP_DLY=8).
module tb_retrosoc_rst_ctrl;

  localparam int HOLD = 16;
  localparam int TDLY = 8;

  logic       clk = 1'b0;
  logic       clk_run = 1'b1;
  logic       rst_n = 1'b0;
  logic       hk = 1'b0;
  logic       trap = 1'b0;
  logic       trap_en = 1'b0;
  logic       sys_rst_n;
  logic [1:0] cause;
  logic [7:0] soft_cnt;
  logic       hold;

  int n_tests = 0;
  int n_fail  = 0;

  retrosoc_rst_ctrl #(
    .HOLD_CYCLES(HOLD),
    .TRAP_DLY   (TDLY)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .hk_rst_i      (hk),
    .trap_i        (trap),
    .trap_rst_en_i (trap_en),
    .sys_rst_n_o   (sys_rst_n),
    .rst_cause_o   (cause),
    .soft_rst_cnt_o(soft_cnt),
    .hold_o        (hold)
  );

  // Gated clock so the async-reset cases can run with no edges.
  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts edges (first edge after the call is 1) until sys_rst_n reaches lvl.
  task automatic wait_level(input logic lvl, input int budget, output int edges);
    edges = 0;
    while (sys_rst_n !== lvl && edges < budget) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  initial begin
    int e;
    int lows;
    int timeouts;

    // Reset state while the pad reset is held with the clock running.
    tick(3);
    check("rst_sys",   32'(sys_rst_n), 32'd0);
    check("rst_hold",  32'(hold),      32'd1);
    check("rst_cause", 32'(cause),     32'd0);
    check("rst_cnt",   32'(soft_cnt),  32'd0);

    // Pad release before edge 0: rise after edge 17 -> 18 edges counted.
    rst_n = 1'b1;
    wait_level(1'b1, 100, e);
    check("pad_rise_edges", 32'(e), 32'(HOLD + 2));
    check("pad_cause", 32'(cause),    32'd0);
    check("pad_cnt",   32'(soft_cnt), 32'd0);
    check("pad_hold",  32'(hold),     32'd0);

    // Housekeeping reset held for 10 sampled edges.
    hk = 1'b1;
    tick(1);
    check("hk_e0_sys", 32'(sys_rst_n), 32'd1);
    tick(1);
    check("hk_e1_sys", 32'(sys_rst_n), 32'd1);
    tick(1);
    check("hk_e2_sys",  32'(sys_rst_n), 32'd0);
    check("hk_e2_hold", 32'(hold),      32'd1);
    tick(7);
    hk = 1'b0;
    wait_level(1'b1, 100, e);
    check("hk_rise_edges", 32'(e), 32'(HOLD + 2));
    check("hk_cause", 32'(cause),    32'd1);
    check("hk_cnt",   32'(soft_cnt), 32'd1);

    // Trap held: reset after edge t+8 -> 9 edges counted.
    trap_en = 1'b1;
    trap    = 1'b1;
    wait_level(1'b0, 100, e);
    check("trap_fall_edges", 32'(e), 32'(TDLY + 1));
    check("trap_cause", 32'(cause),    32'd2);
    check("trap_cnt",   32'(soft_cnt), 32'd2);
    check("trap_hold",  32'(hold),     32'd1);
    trap = 1'b0;
    wait_level(1'b1, 100, e);
    check("trap_rise_edges", 32'(e), 32'(HOLD));

    // Seven-cycle trap pulse: no reset.
    lows = 0;
    trap = 1'b1;
    repeat (7) begin
      tick(1);
      if (!sys_rst_n) lows++;
    end
    trap = 1'b0;
    repeat (20) begin
      tick(1);
      if (!sys_rst_n) lows++;
    end
    check("short_trap_lows", 32'(lows), 32'd0);
    check("short_trap_cnt",  32'(soft_cnt), 32'd2);

    // Trap auto-reset disabled: no reset.
    trap_en = 1'b0;
    trap    = 1'b1;
    lows    = 0;
    repeat (30) begin
      tick(1);
      if (!sys_rst_n) lows++;
    end
    trap = 1'b0;
    check("trap_dis_lows", 32'(lows), 32'd0);
    check("trap_dis_cnt",  32'(soft_cnt), 32'd2);

    // hk_sync arrives on the trap-expiry edge t+8: cause must be housekeeping.
    trap_en = 1'b1;
    trap    = 1'b1;
    tick(6);
    hk = 1'b1;
    tick(2);
    check("coll_pre_sys", 32'(sys_rst_n), 32'd1);
    tick(1);
    check("coll_sys",   32'(sys_rst_n), 32'd0);
    check("coll_cause", 32'(cause),     32'd1);
    check("coll_cnt",   32'(soft_cnt),  32'd3);
    hk   = 1'b0;
    trap = 1'b0;
    wait_level(1'b1, 100, e);
    check("coll_rise_edges", 32'(e), 32'(HOLD + 2));
    check("coll_cnt_after",  32'(soft_cnt), 32'd3);

    // Pad reset mid-TRAP_WAIT with the clock stopped.
    trap = 1'b1;
    tick(3);
    clk_run = 1'b0;
    #2;
    check("async_tw_pre_sys", 32'(sys_rst_n), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_tw_sys",   32'(sys_rst_n), 32'd0);
    check("async_tw_hold",  32'(hold),      32'd1);
    check("async_tw_cause", 32'(cause),     32'd0);
    check("async_tw_cnt",   32'(soft_cnt),  32'd0);
    trap = 1'b0;
    #5;
    rst_n = 1'b1;
    #5;
    clk_run = 1'b1;
    wait_level(1'b1, 100, e);
    check("async_tw_rise_edges", 32'(e), 32'(HOLD + 2));

    // 300 housekeeping pulses saturate the counter at 255.
    timeouts = 0;
    for (int i = 0; i < 300; i++) begin
      hk = 1'b1;
      tick(3);
      hk = 1'b0;
      wait_level(1'b1, 40, e);
      if (e >= 40) timeouts++;
    end
    check("sat_timeouts", 32'(timeouts), 32'd0);
    check("sat_cnt",      32'(soft_cnt), 32'd255);
    check("sat_cause",    32'(cause),    32'd1);

    // Pad reset clears count and cause.
    rst_n = 1'b0;
    tick(2);
    check("pad2_cnt",   32'(soft_cnt),  32'd0);
    check("pad2_cause", 32'(cause),     32'd0);
    check("pad2_sys",   32'(sys_rst_n), 32'd0);

    // Pad reset mid-HOLD at hold count 9 (after edge 10), clock stopped.
    rst_n = 1'b1;
    tick(11);
    check("midhold_sys", 32'(sys_rst_n), 32'd0);
    clk_run = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midhold_async_sys",  32'(sys_rst_n), 32'd0);
    check("midhold_async_hold", 32'(hold),      32'd1);
    #5;
    rst_n = 1'b1;
    #5;
    clk_run = 1'b1;
    wait_level(1'b1, 100, e);
    check("midhold_rise_edges", 32'(e), 32'(HOLD + 2));
    check("midhold_cnt",   32'(soft_cnt), 32'd0);
    check("midhold_cause", 32'(cause),    32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net in case the clock or a wait misbehaves.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
